// File: rtl/aes_encrypt_core_if.sv
// Start/done handshake and data bus for aes_encrypt_core.
// AES_BUSY exists only when AES_ENC_BUSY_EN is defined.
interface aes_encrypt_core_if;
  logic         AES_START;
  logic         AES_DONE;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_PT;
  logic [127:0] AES_MSG_ENC;
`ifdef AES_ENC_BUSY_EN
  logic         AES_BUSY;
`endif

  modport master (
    output AES_START, AES_KEY, AES_MSG_PT,
    input  AES_DONE, AES_MSG_ENC
`ifdef AES_ENC_BUSY_EN
    , input AES_BUSY
`endif
  );

  modport slave (
    input  AES_START, AES_KEY, AES_MSG_PT,
    output AES_DONE, AES_MSG_ENC
`ifdef AES_ENC_BUSY_EN
    , output AES_BUSY
`endif
  );
endinterface

// File: rtl/aes_encrypt_core.sv
// AES-128 encryption core: one full round per clock, round keys expanded on the fly.
// Optional macro AES_ENC_BUSY_EN adds the AES_BUSY output (high while in ROUND).
//
// state | meaning
// IDLE  | waiting for AES_START; AES_MSG_ENC keeps the last ciphertext
// ROUND | rounds 1..10, one per clock; round 10 writes AES_MSG_ENC
// DONE  | AES_DONE=1; held while AES_START=1, leaves on first AES_START=0
module aes_encrypt_core (
  input logic               CLK,
  input logic               RESET_N,
  aes_encrypt_core_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // S-box table, entry 0 in the top byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]   fsm;
  logic [127:0] st;
  logic [127:0] keyreg;
  logic [127:0] enc_q;
  logic [3:0]   rnd;

  logic [31:0]  temp, n0, n1, n2, n3;
  logic [127:0] next_key, sr, mc, round_out;

  // Next round key: RotWord, SubWord, Rcon, then chained XOR across the words
  always_comb begin
    temp = {sbox(keyreg[23:16]), sbox(keyreg[15:8]), sbox(keyreg[7:0]), sbox(keyreg[31:24])}
           ^ {rcon(rnd), 24'h000000};
    n0 = keyreg[127:96] ^ temp;
    n1 = keyreg[95:64]  ^ n0;
    n2 = keyreg[63:32]  ^ n1;
    n3 = keyreg[31:0]   ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // SubBytes + ShiftRows: byte (row r, col c) takes old byte (r, c+r mod 4)
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127 - 8*(r + 4*c) -: 8] = sbox(st[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
      end
    end
  end

  // MixColumns on each column, then key addition (round 10 skips MixColumns)
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127 - 32*c -: 8];
      a1 = sr[119 - 32*c -: 8];
      a2 = sr[111 - 32*c -: 8];
      a3 = sr[103 - 32*c -: 8];
      mc[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    round_out = ((rnd == 4'd10) ? sr : mc) ^ next_key;
  end

  // Sequencer and datapath registers; inputs are captured only on the accept edge
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm    <= IDLE;
      st     <= '0;
      keyreg <= '0;
      enc_q  <= '0;
      rnd    <= 4'd0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.AES_START) begin
            st     <= bus.AES_MSG_PT ^ bus.AES_KEY;
            keyreg <= bus.AES_KEY;
            rnd    <= 4'd1;
            enc_q  <= '0;
            fsm    <= ROUND;
          end
        end
        ROUND: begin
          keyreg <= next_key;
          if (rnd >= 4'd10) begin
            enc_q <= round_out;
            fsm   <= DONE;
          end else begin
            st  <= round_out;
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (!bus.AES_START) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.AES_DONE    = (fsm == DONE);
  assign bus.AES_MSG_ENC = enc_q;
`ifdef AES_ENC_BUSY_EN
  assign bus.AES_BUSY    = (fsm == ROUND);
`endif

endmodule

// File: tb/tb_aes_encrypt_core.sv
module tb_aes_encrypt_core;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  aes_encrypt_core_if aes_bus();
  aes_encrypt_core dut (.CLK(CLK), .RESET_N(RESET_N), .bus(aes_bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    bit           pulse;
    bit           scramble;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_done"}, 128'(aes_bus.AES_DONE), 128'(0));
    check({name, "_enc"}, aes_bus.AES_MSG_ENC, 128'(0));
`ifdef AES_ENC_BUSY_EN
    check({name, "_busy"}, 128'(aes_bus.AES_BUSY), 128'(0));
`endif
  endtask

  // One operation: accept edge then 10 round edges; inputs change at negedges
  task automatic do_op(input vec_t v);
    int busy_cnt;
    busy_cnt = 0;
    @(negedge CLK);
    aes_bus.AES_KEY    = v.key;
    aes_bus.AES_MSG_PT = v.pt;
    aes_bus.AES_START  = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      @(negedge CLK);
`ifdef AES_ENC_BUSY_EN
      if (aes_bus.AES_BUSY) busy_cnt++;
`endif
      if (e == 1) begin
        check("enc_cleared_on_accept", aes_bus.AES_MSG_ENC, 128'(0));
        if (v.pulse) aes_bus.AES_START = 1'b0;
      end
      if (v.scramble && e == 4) begin
        aes_bus.AES_KEY    = ~v.key;
        aes_bus.AES_MSG_PT = {$urandom, $urandom, $urandom, $urandom};
      end
      if (e < 11) check("done_early", 128'(aes_bus.AES_DONE), 128'(0));
    end
    check("done_at_edge11", 128'(aes_bus.AES_DONE), 128'(1));
    check("ciphertext", aes_bus.AES_MSG_ENC, v.ct);
`ifdef AES_ENC_BUSY_EN
    check("busy_cycles", 128'(busy_cnt), 128'(10));
`endif
    if (!v.pulse) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge CLK);
        check("done_held", 128'(aes_bus.AES_DONE), 128'(1));
      end
      aes_bus.AES_START = 1'b0;
    end
    @(negedge CLK);
    check("done_released", 128'(aes_bus.AES_DONE), 128'(0));
    check("enc_retained", aes_bus.AES_MSG_ENC, v.ct);
    @(negedge CLK);
    check("no_retrigger", 128'(aes_bus.AES_DONE), 128'(0));
  endtask

  initial begin
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b0};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 1'b0, 1'b1};
    vecs[2] = '{128'h0, 128'h0,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b1, 1'b0};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                128'h3ad77bb40d7a3660a89ecaf32466ef97, 1'b1, 1'b1};

    aes_bus.AES_START  = 1'b0;
    aes_bus.AES_KEY    = '0;
    aes_bus.AES_MSG_PT = '0;
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    check_idle_outputs("reset");
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    check_idle_outputs("post_reset_idle");

    for (int i = 0; i < 4; i++) do_op(vecs[i]);

    // Reset during round 5: outputs drop immediately, then a clean restart
    @(negedge CLK);
    aes_bus.AES_KEY    = vecs[0].key;
    aes_bus.AES_MSG_PT = vecs[0].pt;
    aes_bus.AES_START  = 1'b1;
    repeat (6) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check_idle_outputs("reset_mid_round");
    aes_bus.AES_START = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check_idle_outputs("after_mid_reset");
    do_op(vecs[1]);

    // Reset while in DONE clears the visible ciphertext
    @(negedge CLK);
    aes_bus.AES_KEY    = vecs[0].key;
    aes_bus.AES_MSG_PT = vecs[0].pt;
    aes_bus.AES_START  = 1'b1;
    @(negedge CLK);
    aes_bus.AES_START = 1'b0;
    repeat (10) @(negedge CLK);
    check("done_before_reset", 128'(aes_bus.AES_DONE), 128'(1));
    check("ct_before_reset", aes_bus.AES_MSG_ENC, vecs[0].ct);
    RESET_N = 1'b0;
    #1;
    check_idle_outputs("reset_in_done");
    @(negedge CLK);
    RESET_N = 1'b1;
    do_op(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_encrypt_core.md
AES_ENCRYPT_CORE -- requirements
Module: aes_encrypt_core

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at AES-128.
REQ-002 CLK  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 AES_START  input  1  level-held start request, part of the start/done handshake.
REQ-005 AES_DONE  output  1  ciphertext valid; handshake acknowledge.
REQ-006 AES_KEY  input  128  cipher key; AES_KEY[127:120] is key byte 0.
REQ-007 AES_MSG_PT  input  128  plaintext; AES_MSG_PT[127:120] is state byte 0, column-major per FIPS-197.
REQ-008 AES_MSG_ENC  output  128  ciphertext, in the same byte order as AES_MSG_PT.
REQ-009 AES_BUSY  output  1  present only under AES_ENC_BUSY_EN (see Configuration).

Function
REQ-010 The FSM SHALL have exactly the states IDLE, ROUND and DONE.
REQ-011 In IDLE with AES_START=1 (the accept edge), the block SHALL latch state<=AES_MSG_PT^AES_KEY, keyreg<=AES_KEY, round<=1 and AES_MSG_ENC<=0, and SHALL enter ROUND.
REQ-012 AES_KEY and AES_MSG_PT SHALL be sampled only at the accept edge; later changes SHALL be ignored until the next accept.
REQ-013 In ROUND, each cycle SHALL compute the next round key on the fly from keyreg: RotWord, SubWord (4 S-boxes), Rcon[round], then the chained XOR of words 1-3.
REQ-014 Rcon SHALL be 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-015 For rounds 1-9, each ROUND cycle SHALL update state<=MixColumns(ShiftRows(SubBytes(state)))^nextkey, keyreg<=nextkey and round<=round+1.
REQ-016 Round 10 SHALL omit MixColumns; that edge SHALL write the result to AES_MSG_ENC and enter DONE.
REQ-017 One full round SHALL complete per clock; the datapath SHALL use 16 state S-boxes and 4 key S-boxes.
REQ-018 Latency: AES_DONE SHALL rise after exactly 11 rising edges counting the accept edge (1 load edge plus 10 round edges).
REQ-019 In DONE, AES_DONE SHALL be 1 and AES_MSG_ENC SHALL hold the ciphertext.
REQ-020 In DONE, the FSM SHALL remain in DONE while AES_START=1 and SHALL return to IDLE on the first edge with AES_START=0.
REQ-021 Deasserting AES_START during ROUND SHALL NOT abort the operation; on completion DONE SHALL last exactly one cycle.
REQ-022 AES_START held high through DONE and IDLE SHALL NOT retrigger; a new accept SHALL require AES_START to be sampled 0 in DONE first.
REQ-023 AES_MSG_ENC SHALL retain the last ciphertext in IDLE until the next accept edge clears it.
REQ-024 The round counter SHALL be 4 bits and SHALL NOT exceed 10; any unused FSM encoding SHALL transition to IDLE.

Reset
REQ-025 On RESET_N=0 the block SHALL immediately enter IDLE with AES_DONE=0, AES_MSG_ENC=0, state=0, keyreg=0, round=0 (and AES_BUSY=0 when present).
REQ-026 Reset asserted during ROUND or DONE SHALL abort the operation with no partial result visible on AES_MSG_ENC.
REQ-027 After RESET_N deasserts, the first accept SHALL require AES_START=1 sampled in IDLE.

Configuration
REQ-028 Macro AES_ENC_BUSY_EN: when defined, port AES_BUSY SHALL exist and SHALL be 1 exactly while in ROUND.
REQ-029 When AES_ENC_BUSY_EN is undefined, the AES_BUSY port SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Key 000102030405060708090a0b0c0d0e0f, PT 00112233445566778899aabbccddeeff, START held -> AES_MSG_ENC=69c4e0d86a7b0430d8cdb78070b4c55a and AES_DONE=1 at edge 11.
REQ-031 Key 2b7e151628aed2a6abf7158809cf4f3c, PT 3243f6a8885a308d313198a2e0370734 -> AES_MSG_ENC=3925841d02dc09fbdc118597196a0b32; a mid-run change of AES_KEY has no effect.
REQ-032 START pulsed high for 1 cycle -> same ciphertext, AES_DONE high for exactly 1 cycle, then IDLE.
REQ-033 START held through DONE for 5 cycles, then dropped, then raised -> exactly one new operation, and AES_MSG_ENC reads 0 during it.
REQ-034 RESET_N pulsed low at round 5 -> all outputs 0 immediately; a restart then yields the correct ciphertext at edge 11.
REQ-035 With AES_ENC_BUSY_EN defined -> AES_BUSY is high for exactly 10 cycles per operation and low otherwise.
